// File: rtl/bpred_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bpred_ctrl
//  Description : Gshare branch predictor controller. A table of 2-bit
//                saturating counters indexed by PC XOR global history, with
//                a power-up sweep that initialises every counter to
//                weakly-not-taken, resolve-priority arbitration, speculative
//                history with checkpoint repair, and a saturating
//                mispredict counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module bpred_ctrl #(
    parameter int GHR_W = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    // fetch lookup
    input  logic             lk_valid,
    input  logic [31:0]      lk_pc,
    output logic             lk_ready,
    // prediction result
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [GHR_W-1:0] pred_idx,
    output logic [GHR_W-1:0] pred_ghr,
    // branch resolution
    input  logic             rs_valid,
    output logic             rs_ready,
    input  logic [GHR_W-1:0] rs_idx,
    input  logic [GHR_W-1:0] rs_ghr,
    input  logic             rs_taken,
    input  logic             rs_mispredict,
    // status
    output logic [GHR_W-1:0] ghr,
    output logic             init_busy,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int          c_PHT_N    = 1 << GHR_W;
    localparam logic [0:0]  c_ST_INIT  = 1'b0;
    localparam logic [0:0]  c_ST_RUN   = 1'b1;
    localparam logic [1:0]  c_CNT_INIT = 2'b01;

    logic [1:0]       r_pht [c_PHT_N];
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [GHR_W-1:0] r_sweep;
    logic [GHR_W-1:0] r_ghr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pred_valid;
    logic             r_pred_taken;
    logic [GHR_W-1:0] r_pred_idx;
    logic [GHR_W-1:0] r_pred_ghr;

    logic             w_init_busy;
    logic             w_rs_ready;
    logic             w_lk_ready;
    logic             w_lk_acc;
    logic             w_rs_acc;
    logic [GHR_W-1:0] w_lk_idx;
    logic [GHR_W-1:0] w_rd_idx;
    logic [1:0]       w_rd_cnt;
    logic [1:0]       w_upd_cnt;

    // Bits of the inputs that do not take part in indexing or history repair.
    logic w_unused;
    assign w_unused = &{1'b0, lk_pc[31:GHR_W+2], lk_pc[1:0], rs_ghr[GHR_W-1]};

    // State register: reset always returns to the initialisation sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs; resolve wins over lookup in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_init_busy = 1'b0;
        w_rs_ready  = 1'b0;
        w_lk_ready  = 1'b0;
        case (r_state)
            c_ST_INIT: begin
                w_init_busy = 1'b1;
                if (r_sweep == {GHR_W{1'b1}}) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                w_rs_ready = 1'b1;
                w_lk_ready = !rs_valid;
            end
            default: w_state_nxt = c_ST_INIT;
        endcase
    end

    assign w_lk_acc = lk_valid & w_lk_ready;
    assign w_rs_acc = rs_valid & w_rs_ready;
    assign w_lk_idx = lk_pc[GHR_W+1:2] ^ r_ghr;

    // Single table read port shared by lookup and resolve read-modify-write.
    assign w_rd_idx = w_rs_acc ? rs_idx : w_lk_idx;
    assign w_rd_cnt = r_pht[w_rd_idx];

    // Saturating 2-bit counter update for a resolved branch.
    always_comb begin
        w_upd_cnt = w_rd_cnt;
        if (rs_taken) begin
            if (w_rd_cnt != 2'b11) w_upd_cnt = w_rd_cnt + 2'b01;
        end else begin
            if (w_rd_cnt != 2'b00) w_upd_cnt = w_rd_cnt - 2'b01;
        end
    end

    // Table write: one sweep entry per cycle in INIT, resolve update in RUN.
    always_ff @(posedge clk) begin
        if (r_state == c_ST_INIT) begin
            r_pht[r_sweep] <= c_CNT_INIT;
        end else if (w_rs_acc) begin
            r_pht[rs_idx] <= w_upd_cnt;
        end
    end

    // Sweep pointer walks the table once; it wraps back to zero on exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sweep <= '0;
        end else if (r_state == c_ST_INIT) begin
            r_sweep <= r_sweep + 1'b1;
        end
    end

    // Speculative history: shift in predictions, repair from checkpoint on mispredict.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ghr <= '1;
        end else if (w_rs_acc) begin
            if (rs_mispredict) begin
                r_ghr <= {rs_ghr[GHR_W-2:0], rs_taken};
            end
        end else if (w_lk_acc) begin
            r_ghr <= {r_ghr[GHR_W-2:0], w_rd_cnt[1]};
        end
    end

    // Mispredict counter sticks at all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_rs_acc && rs_mispredict && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Prediction result is valid for one cycle after an accepted lookup; fields hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_idx   <= '0;
            r_pred_ghr   <= '0;
        end else begin
            r_pred_valid <= w_lk_acc;
            if (w_lk_acc) begin
                r_pred_taken <= w_rd_cnt[1];
                r_pred_idx   <= w_lk_idx;
                r_pred_ghr   <= r_ghr;
            end
        end
    end

    assign lk_ready    = w_lk_ready;
    assign rs_ready    = w_rs_ready;
    assign init_busy   = w_init_busy;
    assign pred_valid  = r_pred_valid;
    assign pred_taken  = r_pred_taken;
    assign pred_idx    = r_pred_idx;
    assign pred_ghr    = r_pred_ghr;
    assign ghr         = r_ghr;
    assign mispred_cnt = r_cnt;

endmodule
`default_nettype wire
